// File: rtl/elapsed_timer_pkg.sv
// Shared state encoding and default sizing for the elapsed-time counter bank.
package elapsed_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      SAT  = 2'd3
   } state_e;

   localparam int unsigned DEF_CHANNELS = 4;
   localparam int unsigned DEF_CNT_W    = 16;
   localparam int unsigned DEF_DIV_W    = 24;
   localparam int unsigned DEF_TICK_DIV = 8192;

endpackage

// File: rtl/elapsed_timer_channel.sv
// One elapsed-time channel: control FSM, prescaler, count, sticky overflow and tick pulse.
module elapsed_timer_channel
   import elapsed_timer_pkg::*;
#(
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned DIV_W     = DEF_DIV_W,
   parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
   parameter bit          WRAP_MODE = 1'b0
) (
   input  logic             MCLK,
   input  logic             nRESET,
   input  logic             nstart_i,
   input  logic             nstop_i,
   input  logic             nclr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             ovfl_o,
   output logic             running_o,
   output logic             tick_o
);

   if (TICK_DIV < 2 || longint'(TICK_DIV) > (longint'(1) << DIV_W)) begin : g_bad_div
      $error("elapsed_timer_channel: TICK_DIV out of range for DIV_W");
   end

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovfl_q, ovfl_d;
   logic             tick_q, tick_d;

   always_ff @(posedge MCLK) begin
      if (!nRESET) begin
         state_q <= IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         ovfl_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         ovfl_q  <= ovfl_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      ovfl_d  = ovfl_q;
      tick_d  = 1'b0;

      if (!nclr_i) begin
         state_d = IDLE;
         presc_d = '0;
         cnt_d   = '0;
         ovfl_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               // A held stop outranks start, so the channel stays put until stop releases.
               if (nstop_i && !nstart_i) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!nstop_i) begin
                  state_d = HOLD;
               end else if (presc_q == PRESC_LAST) begin
                  if (cnt_q == CNT_MAX) begin
                     ovfl_d = 1'b1;
                     if (WRAP_MODE) begin
                        presc_d = '0;
                        cnt_d   = '0;
                        tick_d  = 1'b1;
                     end else begin
                        state_d = SAT;
                     end
                  end else begin
                     presc_d = '0;
                     cnt_d   = cnt_q + CNT_W'(1);
                     tick_d  = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + DIV_W'(1);
               end
            end
            SAT: begin
               state_d = SAT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign count_o   = cnt_q;
   assign ovfl_o    = ovfl_q;
   assign running_o = (state_q == RUN);
   assign tick_o    = tick_q;

endmodule

// File: rtl/elapsed_timer_bank.sv
// Bank of independent elapsed-time channels with packed status outputs.
// Optional coherent snapshot register enabled by ELAPSED_TIMER_CAPTURE_EN.
module elapsed_timer_bank
   import elapsed_timer_pkg::*;
#(
   parameter int unsigned CHANNELS  = DEF_CHANNELS,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned DIV_W     = DEF_DIV_W,
   parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
   parameter int unsigned WRAP_MODE = 0
) (
   input  logic                      MCLK,
   input  logic                      nRESET,
   input  logic [CHANNELS-1:0]       nSTART,
   input  logic [CHANNELS-1:0]       nSTOP,
   input  logic [CHANNELS-1:0]       nCLR,
   output logic [CHANNELS*CNT_W-1:0] TIMEELAPSED,
   output logic [CHANNELS-1:0]       OVFL,
   output logic [CHANNELS-1:0]       RUNNING,
   output logic [CHANNELS-1:0]       TICK
`ifdef ELAPSED_TIMER_CAPTURE_EN
   ,
   input  logic                      nCAPTURE,
   output logic [CHANNELS*CNT_W-1:0] CAPTURED
`endif
);

   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("elapsed_timer_bank: CHANNELS must be 1..16");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      elapsed_timer_channel #(
         .CNT_W     (CNT_W),
         .DIV_W     (DIV_W),
         .TICK_DIV  (TICK_DIV),
         .WRAP_MODE (WRAP_MODE != 0)
      ) u_ch (
         .MCLK      (MCLK),
         .nRESET    (nRESET),
         .nstart_i  (nSTART[i]),
         .nstop_i   (nSTOP[i]),
         .nclr_i    (nCLR[i]),
         .count_o   (TIMEELAPSED[i*CNT_W +: CNT_W]),
         .ovfl_o    (OVFL[i]),
         .running_o (RUNNING[i]),
         .tick_o    (TICK[i])
      );
   end

`ifdef ELAPSED_TIMER_CAPTURE_EN
   logic                      ncap_q;
   logic [CHANNELS*CNT_W-1:0] captured_q;

   // Sampling the registered counts in the edge cycle yields pre-increment values.
   always_ff @(posedge MCLK) begin
      if (!nRESET) begin
         ncap_q     <= 1'b1;
         captured_q <= '0;
      end else begin
         ncap_q <= nCAPTURE;
         if (ncap_q && !nCAPTURE) begin
            captured_q <= TIMEELAPSED;
         end
      end
   end

   assign CAPTURED = captured_q;
`endif

endmodule

// File: tb/tb_elapsed_timer_bank.sv
// Directed bench for elapsed_timer_bank: saturating and wrapping instances share stimulus.
module tb_elapsed_timer_bank;

   logic       MCLK = 1'b0;
   logic       nRESET;
   logic [1:0] nstart, nstop, nclr;
   logic       ncap;
   logic [7:0] te_s, te_w;
   logic [1:0] ov_s, ov_w, rn_s, rn_w, tk_s, tk_w;
`ifdef ELAPSED_TIMER_CAPTURE_EN
   logic [7:0] cap_s, cap_w;
`endif

   int checks = 0;
   int errors = 0;

   always #5 MCLK = ~MCLK;

   elapsed_timer_bank #(
      .CHANNELS (2), .CNT_W (4), .DIV_W (3), .TICK_DIV (4), .WRAP_MODE (0)
   ) dut (
      .MCLK (MCLK), .nRESET (nRESET), .nSTART (nstart), .nSTOP (nstop), .nCLR (nclr),
      .TIMEELAPSED (te_s), .OVFL (ov_s), .RUNNING (rn_s), .TICK (tk_s)
`ifdef ELAPSED_TIMER_CAPTURE_EN
      , .nCAPTURE (ncap), .CAPTURED (cap_s)
`endif
   );

   elapsed_timer_bank #(
      .CHANNELS (2), .CNT_W (4), .DIV_W (3), .TICK_DIV (4), .WRAP_MODE (1)
   ) dut_w (
      .MCLK (MCLK), .nRESET (nRESET), .nSTART (nstart), .nSTOP (nstop), .nCLR (nclr),
      .TIMEELAPSED (te_w), .OVFL (ov_w), .RUNNING (rn_w), .TICK (tk_w)
`ifdef ELAPSED_TIMER_CAPTURE_EN
      , .nCAPTURE (ncap), .CAPTURED (cap_w)
`endif
   );

   typedef struct {
      logic [1:0] st, sp, cl;
      logic [7:0] te;
      logic [1:0] ov, rn, tk;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [1:0] st, sp, cl, input logic [7:0] te,
                               input logic [1:0] ov, rn, tk);
      vec_t v;
      v.st = st; v.sp = sp; v.cl = cl; v.te = te; v.ov = ov; v.rn = rn; v.tk = tk;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] cl);
      nstart = st;
      nstop  = sp;
      nclr   = cl;
      @(posedge MCLK);
      #1;
   endtask

   task automatic chk_both(input string name, input logic [7:0] te, input logic [1:0] ov,
                           input logic [1:0] rn, input logic [1:0] tk);
      chk({name, " te_s"}, te_s, te);
      chk({name, " ov_s"}, ov_s, ov);
      chk({name, " rn_s"}, rn_s, rn);
      chk({name, " tk_s"}, tk_s, tk);
      chk({name, " te_w"}, te_w, te);
      chk({name, " ov_w"}, ov_w, ov);
      chk({name, " rn_w"}, rn_w, rn);
      chk({name, " tk_w"}, tk_w, tk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRESET = 1'b0;
      nstart = 2'b11;
      nstop  = 2'b11;
      nclr   = 2'b11;
      ncap   = 1'b1;

      // Single start pulse on ch0: ticks 4, 8, 12 cycles after RUN entry; ch1 idle.
      add(2'b10, 2'b11, 2'b11, 8'h00, 2'b00, 2'b01, 2'b00);
      for (int k = 1; k <= 12; k++) begin
         add(2'b11, 2'b11, 2'b11, {4'h0, 4'(k / 4)}, 2'b00, 2'b01,
             (k % 4 == 0) ? 2'b01 : 2'b00);
      end
      add(2'b11, 2'b11, 2'b10, 8'h00, 2'b00, 2'b00, 2'b00);
      // Stop lands on the increment cycle; increment fires on first cycle after resume.
      add(2'b10, 2'b11, 2'b11, 8'h00, 2'b00, 2'b01, 2'b00);
      for (int k = 1; k <= 3; k++) add(2'b11, 2'b11, 2'b11, 8'h00, 2'b00, 2'b01, 2'b00);
      for (int k = 0; k < 9; k++) add(2'b11, 2'b10, 2'b11, 8'h00, 2'b00, 2'b00, 2'b00);
      add(2'b10, 2'b10, 2'b11, 8'h00, 2'b00, 2'b00, 2'b00);
      add(2'b10, 2'b11, 2'b11, 8'h00, 2'b00, 2'b01, 2'b00);
      add(2'b11, 2'b11, 2'b11, 8'h01, 2'b00, 2'b01, 2'b01);
      for (int k = 0; k < 3; k++) add(2'b11, 2'b11, 2'b11, 8'h01, 2'b00, 2'b01, 2'b00);
      add(2'b11, 2'b11, 2'b11, 8'h02, 2'b00, 2'b01, 2'b01);
      add(2'b11, 2'b11, 2'b10, 8'h00, 2'b00, 2'b00, 2'b00);

      step(2'b11, 2'b11, 2'b11);
      step(2'b11, 2'b11, 2'b11);
      chk_both("reset", 8'h00, 2'b00, 2'b00, 2'b00);
`ifdef ELAPSED_TIMER_CAPTURE_EN
      chk("reset cap", cap_s, 8'h00);
`endif
      nRESET = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].sp, tbl[i].cl);
         chk_both($sformatf("vec%0d", i), tbl[i].te, tbl[i].ov, tbl[i].rn, tbl[i].tk);
      end

      // Overflow: saturating instance halts at 15, wrapping instance rolls to 0.
      for (int k = 0; k <= 71; k++) begin
         logic [3:0] cs, cw;
         logic       tks, tkw;
         step((k == 0) ? 2'b10 : 2'b11, 2'b11, 2'b11);
         cs  = (k < 64) ? 4'(k / 4) : 4'hF;
         cw  = 4'((k / 4) % 16);
         tkw = (k > 0) && (k % 4 == 0);
         tks = tkw && (k < 64);
         chk($sformatf("ovf k%0d te_s", k), te_s, {4'h0, cs});
         chk($sformatf("ovf k%0d ov_s", k), ov_s, {1'b0, k >= 64});
         chk($sformatf("ovf k%0d rn_s", k), rn_s, {1'b0, k < 64});
         chk($sformatf("ovf k%0d tk_s", k), tk_s, {1'b0, tks});
         chk($sformatf("ovf k%0d te_w", k), te_w, {4'h0, cw});
         chk($sformatf("ovf k%0d ov_w", k), ov_w, {1'b0, k >= 64});
         chk($sformatf("ovf k%0d rn_w", k), rn_w, 2'b01);
         chk($sformatf("ovf k%0d tk_w", k), tk_w, {1'b0, tkw});
      end

      // Clear, stop and start together on a wrapping increment cycle.
      step(2'b10, 2'b10, 2'b10);
      chk_both("allctl", 8'h00, 2'b00, 2'b00, 2'b00);
      step(2'b11, 2'b11, 2'b11);
      chk_both("allctl idle", 8'h00, 2'b00, 2'b00, 2'b00);

      // Reset mid-run on both channels.
      step(2'b00, 2'b11, 2'b11);
      for (int k = 1; k <= 5; k++) step(2'b11, 2'b11, 2'b11);
      chk_both("both run", 8'h11, 2'b00, 2'b11, 2'b00);
      nRESET = 1'b0;
      step(2'b11, 2'b11, 2'b11);
      chk_both("midreset", 8'h00, 2'b00, 2'b00, 2'b00);
      nRESET = 1'b1;

`ifdef ELAPSED_TIMER_CAPTURE_EN
      // ch1 starts 14 cycles ahead so it reads 9 while ch0 is at its 5->6 tick cycle.
      step(2'b01, 2'b11, 2'b11);
      for (int k = 0; k < 13; k++) step(2'b11, 2'b11, 2'b11);
      step(2'b10, 2'b11, 2'b11);
      for (int k = 0; k < 23; k++) step(2'b11, 2'b11, 2'b11);
      chk("pre cap te", te_s, 8'h95);
      chk("pre cap cap", cap_s, 8'h00);
      ncap = 1'b0;
      step(2'b11, 2'b11, 2'b11);
      chk("cap value", cap_s, 8'h95);
      chk("cap te", te_s, 8'h96);
      chk("cap tick", tk_s, 2'b01);
      step(2'b11, 2'b11, 2'b11);
      chk("cap held low", cap_s, 8'h95);
      ncap = 1'b1;
      step(2'b11, 2'b11, 2'b11);
      chk("cap released", cap_s, 8'h95);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
